nnrv_mem: RTL and testbench

//  Memory stage directly downstream of the execute stage. Consumes execute's rd/rd_reg and RAM request fields.

---
 rtl/nnrv_pkg.sv | 17 +
 rtl/nnrv_load_align.sv | 45 ++++
 rtl/nnrv_mem.sv | 224 ++++++++++++++++++++++
 tb/tb_nnrv_mem.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nnrv_pkg.sv
// Shared types and constants for the nnrv memory stage: FSM states and the
// normalised byte-lane masks that select the load size.
package nnrv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // Lane masks after shifting down by the address offset.
    localparam logic [7:0] SIZE_MASK_B = 8'h01;
    localparam logic [7:0] SIZE_MASK_H = 8'h03;
    localparam logic [7:0] SIZE_MASK_W = 8'h0F;
    localparam logic [7:0] SIZE_MASK_D = 8'hFF;

endpackage

// File: rtl/nnrv_load_align.sv
// Load alignment: shifts the addressed lanes of a RAM doubleword down to bit 0
// and sign- or zero-extends according to the normalised lane mask.
module nnrv_load_align
    import nnrv_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int MASK_WIDTH = XLEN / 8,
    parameter int OFF_W      = $clog2(MASK_WIDTH)
) (
    input  logic [XLEN-1:0]       rdata,
    input  logic [OFF_W-1:0]      off,
    input  logic [MASK_WIDTH-1:0] mask,
    input  logic                  sign,
    output logic [XLEN-1:0]       result
);

    logic [XLEN-1:0]       lane_data [MASK_WIDTH];
    logic [MASK_WIDTH-1:0] lane_mask [MASK_WIDTH];
    logic [XLEN-1:0]       d;
    logic [MASK_WIDTH-1:0] m;

    genvar gi;
    generate
        for (gi = 0; gi < MASK_WIDTH; gi++) begin : g_lane
            assign lane_data[gi] = rdata >> (gi * 8);
            assign lane_mask[gi] = mask >> gi;
        end
    endgenerate

    assign d = lane_data[off];
    assign m = lane_mask[off];

    // Unrecognised mask shapes fall through to a full-width result.
    always_comb begin
        result = d;
        case (m)
            MASK_WIDTH'(SIZE_MASK_B): result = {{(XLEN-8){sign & d[7]}},   d[7:0]};
            MASK_WIDTH'(SIZE_MASK_H): result = {{(XLEN-16){sign & d[15]}}, d[15:0]};
            MASK_WIDTH'(SIZE_MASK_W): result = {{(XLEN-32){sign & d[31]}}, d[31:0]};
            MASK_WIDTH'(SIZE_MASK_D): result = d;
            default:                  result = d;
        endcase
    end

endmodule

// File: rtl/nnrv_mem.sv
// Memory stage: runs the data-RAM req/ack handshake, aligns load data, passes
// ALU results through, and drives write-back plus the decode forwarding port.
module nnrv_mem
    import nnrv_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int MASK_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_exec_rd_en,
    input  logic [4:0]            i_exec_rd,
    input  logic [XLEN-1:0]       i_exec_rd_reg,
    input  logic                  i_exec_ram_rd_en,
    input  logic                  i_exec_ram_wr_en,
    input  logic [XLEN-1:0]       i_exec_ram_addr,
    input  logic [XLEN-1:0]       i_exec_ram_data,
    input  logic [MASK_WIDTH-1:0] i_exec_ram_mask,
    input  logic                  i_exec_sign,
    output logic                  o_stall,
    output logic                  o_ram_req,
    output logic                  o_ram_we,
    output logic [XLEN-1:0]       o_ram_addr,
    output logic [XLEN-1:0]       o_ram_wdata,
    output logic [MASK_WIDTH-1:0] o_ram_mask,
    input  logic                  i_ram_ack,
    input  logic [XLEN-1:0]       i_ram_rdata,
    output logic                  o_wb_rd_en,
    output logic [4:0]            o_wb_rd,
    output logic [XLEN-1:0]       o_wb_rd_reg,
    output logic                  o_id_rd_en,
    output logic [4:0]            o_id_rd,
    output logic [XLEN-1:0]       o_id_rd_reg,
    output logic                  o_id_rd_ready,
    output logic                  o_err
);

    localparam int OFF_W  = $clog2(MASK_WIDTH);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int LCNT_W = OFF_W + 2;

    mem_state_e            state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  cap_rd_en_reg, cap_rd_en_next;
    logic [4:0]            cap_rd_reg, cap_rd_next;
    logic                  cap_load_reg, cap_load_next;
    logic                  cap_we_reg, cap_we_next;
    logic [XLEN-1:0]       cap_addr_reg, cap_addr_next;
    logic [XLEN-1:0]       cap_data_reg, cap_data_next;
    logic [MASK_WIDTH-1:0] cap_mask_reg, cap_mask_next;
    logic                  cap_sign_reg, cap_sign_next;
    logic                  wb_rd_en_reg, wb_rd_en_next;
    logic [4:0]            wb_rd_reg, wb_rd_next;
    logic [XLEN-1:0]       wb_data_reg, wb_data_next;
    logic                  err_reg, err_next;
    logic                  ready_reg;

    logic                  mem_op;
    logic [LCNT_W-1:0]     lane_cnt;
    logic [MASK_WIDTH-1:0] low_lane;
    logic                  contiguous;
    logic                  misalign;
    logic                  cap_wb_en;
    logic                  in_req;
    logic                  load_pending;
    logic [XLEN-1:0]       load_data;

    nnrv_load_align #(
        .XLEN       (XLEN),
        .MASK_WIDTH (MASK_WIDTH),
        .OFF_W      (OFF_W)
    ) u_load_align (
        .rdata  (i_ram_rdata),
        .off    (cap_addr_reg[OFF_W-1:0]),
        .mask   (cap_mask_reg),
        .sign   (cap_sign_reg),
        .result (load_data)
    );

    assign mem_op = i_exec_ram_rd_en | i_exec_ram_wr_en;

    always_comb begin
        lane_cnt = '0;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            lane_cnt = lane_cnt + LCNT_W'(i_exec_ram_mask[i]);
        end
    end

    // Adding the lowest set lane carries through a single run of ones and
    // leaves any later set lane untouched, exposing a gap in the mask.
    assign low_lane   = i_exec_ram_mask & (~i_exec_ram_mask + MASK_WIDTH'(1));
    assign contiguous = ((i_exec_ram_mask & (i_exec_ram_mask + low_lane)) == '0);
    assign misalign   = ((lane_cnt + LCNT_W'(i_exec_ram_addr[OFF_W-1:0])) > LCNT_W'(MASK_WIDTH))
                        || !contiguous;

    assign cap_wb_en = cap_rd_en_reg & (cap_rd_reg != 5'd0);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        cap_rd_en_next = cap_rd_en_reg;
        cap_rd_next    = cap_rd_reg;
        cap_load_next  = cap_load_reg;
        cap_we_next    = cap_we_reg;
        cap_addr_next  = cap_addr_reg;
        cap_data_next  = cap_data_reg;
        cap_mask_next  = cap_mask_reg;
        cap_sign_next  = cap_sign_reg;
        wb_rd_en_next  = wb_rd_en_reg;
        wb_rd_next     = wb_rd_reg;
        wb_data_next   = wb_data_reg;
        err_next       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (mem_op) begin
                    wb_rd_en_next = 1'b0;
                    if (misalign) begin
                        err_next = 1'b1;
                    end else begin
                        state_next     = ST_REQ;
                        cnt_next       = '0;
                        cap_rd_en_next = i_exec_rd_en;
                        cap_rd_next    = i_exec_rd;
                        // A request with both enables set is carried out as a store.
                        cap_load_next  = i_exec_ram_rd_en & ~i_exec_ram_wr_en;
                        cap_we_next    = i_exec_ram_wr_en;
                        cap_addr_next  = i_exec_ram_addr;
                        cap_data_next  = i_exec_ram_data;
                        cap_mask_next  = i_exec_ram_mask;
                        cap_sign_next  = i_exec_sign;
                        err_next       = i_exec_ram_rd_en & i_exec_ram_wr_en;
                    end
                end else begin
                    wb_rd_en_next = i_exec_rd_en;
                    wb_rd_next    = i_exec_rd;
                    wb_data_next  = i_exec_rd_reg;
                end
            end
            ST_REQ: begin
                if (i_ram_ack) begin
                    state_next    = ST_RESP;
                    cnt_next      = '0;
                    wb_rd_en_next = cap_load_reg & cap_wb_en;
                    wb_rd_next    = cap_rd_reg;
                    wb_data_next  = load_data;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_next    = ST_IDLE;
                wb_rd_en_next = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            cap_rd_en_reg <= 1'b0;
            cap_rd_reg    <= '0;
            cap_load_reg  <= 1'b0;
            cap_we_reg    <= 1'b0;
            cap_addr_reg  <= '0;
            cap_data_reg  <= '0;
            cap_mask_reg  <= '0;
            cap_sign_reg  <= 1'b0;
            wb_rd_en_reg  <= 1'b0;
            wb_rd_reg     <= '0;
            wb_data_reg   <= '0;
            err_reg       <= 1'b0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            cap_rd_en_reg <= cap_rd_en_next;
            cap_rd_reg    <= cap_rd_next;
            cap_load_reg  <= cap_load_next;
            cap_we_reg    <= cap_we_next;
            cap_addr_reg  <= cap_addr_next;
            cap_data_reg  <= cap_data_next;
            cap_mask_reg  <= cap_mask_next;
            cap_sign_reg  <= cap_sign_next;
            wb_rd_en_reg  <= wb_rd_en_next;
            wb_rd_reg     <= wb_rd_next;
            wb_data_reg   <= wb_data_next;
            err_reg       <= err_next;
            ready_reg     <= 1'b1;
        end
    end

    assign in_req       = (state_reg == ST_REQ);
    assign load_pending = in_req & cap_load_reg;

    assign o_stall     = in_req || (state_reg == ST_RESP);
    assign o_ram_req   = in_req;
    assign o_ram_we    = in_req & cap_we_reg;
    assign o_ram_addr  = in_req ? {cap_addr_reg[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign o_ram_wdata = in_req ? cap_data_reg : '0;
    assign o_ram_mask  = in_req ? cap_mask_reg : '0;

    assign o_wb_rd_en  = wb_rd_en_reg;
    assign o_wb_rd     = wb_rd_reg;
    assign o_wb_rd_reg = wb_data_reg;

    // While a load waits on the RAM, decode sees the pending rd marked not ready.
    assign o_id_rd_en    = load_pending ? cap_wb_en  : wb_rd_en_reg;
    assign o_id_rd       = load_pending ? cap_rd_reg : wb_rd_reg;
    assign o_id_rd_reg   = load_pending ? '0         : wb_data_reg;
    assign o_id_rd_ready = ready_reg & ~load_pending;

    assign o_err = err_reg;

endmodule

// File: tb/tb_nnrv_mem.sv
// Self-checking bench for nnrv_mem: scoreboarded write-backs for ALU and load
// traffic, plus stores, misalignment, illegal requests, timeout and reset.
module tb_nnrv_mem;

    localparam int XLEN    = 64;
    localparam int MW      = 8;
    localparam int TIMEOUT = 255;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_exec_rd_en;
    logic [4:0]      i_exec_rd;
    logic [XLEN-1:0] i_exec_rd_reg;
    logic            i_exec_ram_rd_en;
    logic            i_exec_ram_wr_en;
    logic [XLEN-1:0] i_exec_ram_addr;
    logic [XLEN-1:0] i_exec_ram_data;
    logic [MW-1:0]   i_exec_ram_mask;
    logic            i_exec_sign;
    logic            o_stall;
    logic            o_ram_req;
    logic            o_ram_we;
    logic [XLEN-1:0] o_ram_addr;
    logic [XLEN-1:0] o_ram_wdata;
    logic [MW-1:0]   o_ram_mask;
    logic            i_ram_ack;
    logic [XLEN-1:0] i_ram_rdata;
    logic            o_wb_rd_en;
    logic [4:0]      o_wb_rd;
    logic [XLEN-1:0] o_wb_rd_reg;
    logic            o_id_rd_en;
    logic [4:0]      o_id_rd;
    logic [XLEN-1:0] o_id_rd_reg;
    logic            o_id_rd_ready;
    logic            o_err;

    logic [280:0]    all_out;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_t;

    typedef struct {
        logic [XLEN-1:0] addr;
        logic [7:0]      mask;
        logic            sign;
        logic [4:0]      rd;
        logic [XLEN-1:0] rdata;
        int              lat;
        logic [XLEN-1:0] exp;
    } ld_t;

    wb_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    always #5 i_clk = ~i_clk;

    nnrv_mem #(.XLEN(XLEN), .MASK_WIDTH(MW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_exec_rd_en     (i_exec_rd_en),
        .i_exec_rd        (i_exec_rd),
        .i_exec_rd_reg    (i_exec_rd_reg),
        .i_exec_ram_rd_en (i_exec_ram_rd_en),
        .i_exec_ram_wr_en (i_exec_ram_wr_en),
        .i_exec_ram_addr  (i_exec_ram_addr),
        .i_exec_ram_data  (i_exec_ram_data),
        .i_exec_ram_mask  (i_exec_ram_mask),
        .i_exec_sign      (i_exec_sign),
        .o_stall          (o_stall),
        .o_ram_req        (o_ram_req),
        .o_ram_we         (o_ram_we),
        .o_ram_addr       (o_ram_addr),
        .o_ram_wdata      (o_ram_wdata),
        .o_ram_mask       (o_ram_mask),
        .i_ram_ack        (i_ram_ack),
        .i_ram_rdata      (i_ram_rdata),
        .o_wb_rd_en       (o_wb_rd_en),
        .o_wb_rd          (o_wb_rd),
        .o_wb_rd_reg      (o_wb_rd_reg),
        .o_id_rd_en       (o_id_rd_en),
        .o_id_rd          (o_id_rd),
        .o_id_rd_reg      (o_id_rd_reg),
        .o_id_rd_ready    (o_id_rd_ready),
        .o_err            (o_err)
    );

    assign all_out = {o_stall, o_ram_req, o_ram_we, o_ram_addr, o_ram_wdata, o_ram_mask,
                      o_wb_rd_en, o_wb_rd, o_wb_rd_reg, o_id_rd_en, o_id_rd, o_id_rd_reg,
                      o_id_rd_ready, o_err};

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_nop();
        i_exec_rd_en     = 1'b0;
        i_exec_rd        = '0;
        i_exec_rd_reg    = '0;
        i_exec_ram_rd_en = 1'b0;
        i_exec_ram_wr_en = 1'b0;
        i_exec_ram_addr  = '0;
        i_exec_ram_data  = '0;
        i_exec_ram_mask  = '0;
        i_exec_sign      = 1'b0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [XLEN-1:0] addr,
                              input logic [7:0] mask, input logic sign);
        drive_nop();
        i_exec_rd_en     = 1'b1;
        i_exec_rd        = rd;
        i_exec_rd_reg    = 64'h0BAD_0BAD_0BAD_0BAD;
        i_exec_ram_rd_en = 1'b1;
        i_exec_ram_addr  = addr;
        i_exec_ram_mask  = mask;
        i_exec_sign      = sign;
    endtask

    task automatic test_reset();
        drive_nop();
        i_ram_ack   = 1'b0;
        i_ram_rdata = '0;
        i_rst       = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        i_rst = 1'b0;
        tick();
        n_cmp++;
        if (o_stall !== 1'b0 || o_wb_rd_en !== 1'b0 || o_id_rd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: stall=%b wb_en=%b ready=%b required 0/0/1",
                     o_stall, o_wb_rd_en, o_id_rd_ready);
        end
        $display("reset done");
    endtask

    task automatic test_alu();
        wb_t             e;
        logic            en;
        logic [4:0]      rd;
        logic [XLEN-1:0] val;
        for (int k = 0; k < 5; k++) begin
            rd  = (k == 0) ? 5'd5 : 5'(k + 10);
            val = (k == 0) ? 64'h1234 : {$urandom, $urandom};
            en  = (k != 3);
            drive_nop();
            i_exec_rd_en  = en;
            i_exec_rd     = rd;
            i_exec_rd_reg = val;
            if (en) exp_q.push_back('{rd: rd, data: val});
            tick();
            $display("alu rd=%0d en=%b data=%h", rd, en, val);
            n_cmp++;
            if (o_wb_rd_en !== en || o_stall !== 1'b0) begin
                n_bad++;
                $display("FAIL alu_en: wb_en=%b stall=%b required %b/0", o_wb_rd_en, o_stall, en);
            end
            if (o_wb_rd_en === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL alu_unexpected_wb: got rd=%0d required none", o_wb_rd);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_wb_rd, o_wb_rd_reg} !== e ||
                        {o_id_rd_en, o_id_rd, o_id_rd_reg, o_id_rd_ready} !== {1'b1, e, 1'b1}) begin
                        n_bad++;
                        $display("FAIL alu_wb: got rd=%0d data=%h id=%0d/%h rdy=%b required rd=%0d data=%h",
                                 o_wb_rd, o_wb_rd_reg, o_id_rd, o_id_rd_reg, o_id_rd_ready, e.rd, e.data);
                    end
                end
            end
        end
        drive_nop();
        tick();
    endtask

    task automatic test_loads();
        ld_t tbl [8];
        wb_t e;
        int  stall_n;
        tbl[0] = '{64'h1003, 8'h08, 1'b1, 5'd3,  64'h1122_3344_80AA_BBCC, 2, 64'hFFFF_FFFF_FFFF_FF80};
        tbl[1] = '{64'h2004, 8'hF0, 1'b0, 5'd4,  64'hDEAD_BEEF_0000_0000, 0, 64'h0000_0000_DEAD_BEEF};
        tbl[2] = '{64'h1102, 8'h0C, 1'b1, 5'd6,  64'h5555_5555_8765_AAAA, 1, 64'hFFFF_FFFF_FFFF_8765};
        tbl[3] = '{64'h1204, 8'hF0, 1'b1, 5'd8,  64'h8000_0001_1111_1111, 0, 64'hFFFF_FFFF_8000_0001};
        tbl[4] = '{64'h1300, 8'hFF, 1'b1, 5'd31, 64'h0123_4567_89AB_CDEF, 3, 64'h0123_4567_89AB_CDEF};
        tbl[5] = '{64'h1407, 8'h80, 1'b0, 5'd12, 64'hFE11_2233_4455_6677, 0, 64'h0000_0000_0000_00FE};
        tbl[6] = '{64'h1501, 8'h02, 1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_7FFF, 1, 64'h0000_0000_0000_007F};
        tbl[7] = '{64'h1501, 8'h02, 1'b1, 5'd13, 64'hFFFF_FFFF_FFFF_7FFF, 1, 64'h0000_0000_0000_007F};
        for (int k = 0; k < 8; k++) begin
            drive_load(tbl[k].rd, tbl[k].addr, tbl[k].mask, tbl[k].sign);
            if (tbl[k].rd != 5'd0) exp_q.push_back('{rd: tbl[k].rd, data: tbl[k].exp});
            tick();
            drive_nop();
            stall_n = 0;
            n_cmp++;
            if (o_ram_req !== 1'b1 || o_ram_we !== 1'b0 || o_ram_addr !== (tbl[k].addr & ~64'h7) ||
                o_ram_mask !== tbl[k].mask) begin
                n_bad++;
                $display("FAIL ld_req[%0d]: req=%b we=%b addr=%h mask=%h required 1/0/%h/%h", k,
                         o_ram_req, o_ram_we, o_ram_addr, o_ram_mask, tbl[k].addr & ~64'h7, tbl[k].mask);
            end
            n_cmp++;
            if (o_id_rd_ready !== 1'b0 || o_id_rd !== tbl[k].rd) begin
                n_bad++;
                $display("FAIL ld_fwd_pending[%0d]: ready=%b rd=%0d required 0/%0d", k,
                         o_id_rd_ready, o_id_rd, tbl[k].rd);
            end
            for (int c = 0; c < tbl[k].lat; c++) begin
                if (o_stall === 1'b1) stall_n++;
                tick();
            end
            if (o_stall === 1'b1) stall_n++;
            i_ram_ack   = 1'b1;
            i_ram_rdata = tbl[k].rdata;
            tick();
            i_ram_ack   = 1'b0;
            i_ram_rdata = '0;
            if (o_stall === 1'b1) stall_n++;
            $display("ld rd=%0d addr=%h mask=%h lat=%0d wb_en=%b wb=%h", tbl[k].rd, tbl[k].addr,
                     tbl[k].mask, tbl[k].lat, o_wb_rd_en, o_wb_rd_reg);
            n_cmp++;
            if (o_wb_rd_en !== (tbl[k].rd != 5'd0)) begin
                n_bad++;
                $display("FAIL ld_wb_en[%0d]: got %b required %b", k, o_wb_rd_en, tbl[k].rd != 5'd0);
            end
            if (o_wb_rd_en === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL ld_unexpected_wb[%0d]: got rd=%0d required none", k, o_wb_rd);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_wb_rd, o_wb_rd_reg} !== e || o_id_rd_reg !== e.data || o_id_rd_ready !== 1'b1) begin
                        n_bad++;
                        $display("FAIL ld_data[%0d]: got rd=%0d data=%h id=%h required rd=%0d data=%h", k,
                                 o_wb_rd, o_wb_rd_reg, o_id_rd_reg, e.rd, e.data);
                    end
                end
            end
            tick();
            n_cmp++;
            if (stall_n != tbl[k].lat + 2 || o_stall !== 1'b0) begin
                n_bad++;
                $display("FAIL ld_stall[%0d]: got %0d cycles (now %b) required %0d (now 0)", k,
                         stall_n, o_stall, tbl[k].lat + 2);
            end
        end
    endtask

    task automatic test_stores();
        logic [XLEN-1:0] addr [2];
        logic [7:0]      mask [2];
        logic [XLEN-1:0] data [2];
        addr[0] = 64'h3000; mask[0] = 8'hFF; data[0] = 64'hA5A5_A5A5_A5A5_A5A5;
        addr[1] = 64'h3005; mask[1] = 8'h60; data[1] = 64'h0012_3400_0000_0000;
        for (int k = 0; k < 2; k++) begin
            drive_nop();
            i_exec_ram_wr_en = 1'b1;
            i_exec_ram_addr  = addr[k];
            i_exec_ram_mask  = mask[k];
            i_exec_ram_data  = data[k];
            tick();
            drive_nop();
            $display("st addr=%h mask=%h data=%h", addr[k], mask[k], data[k]);
            n_cmp++;
            if (o_ram_req !== 1'b1 || o_ram_we !== 1'b1 || o_ram_addr !== {addr[k][63:3], 3'b000} ||
                o_ram_mask !== mask[k] || o_ram_wdata !== data[k] || o_id_rd_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL st_req[%0d]: req=%b we=%b addr=%h mask=%h wdata=%h rdy=%b required 1/1/%h/%h/%h/1",
                         k, o_ram_req, o_ram_we, o_ram_addr, o_ram_mask, o_ram_wdata, o_id_rd_ready,
                         {addr[k][63:3], 3'b000}, mask[k], data[k]);
            end
            i_ram_ack = 1'b1;
            tick();
            i_ram_ack = 1'b0;
            n_cmp++;
            if (o_wb_rd_en !== 1'b0 || o_stall !== 1'b1 || o_ram_req !== 1'b0) begin
                n_bad++;
                $display("FAIL st_resp[%0d]: wb_en=%b stall=%b req=%b required 0/1/0", k,
                         o_wb_rd_en, o_stall, o_ram_req);
            end
            tick();
            n_cmp++;
            if (o_stall !== 1'b0) begin
                n_bad++;
                $display("FAIL st_done[%0d]: stall=%b required 0", k, o_stall);
            end
        end
    endtask

    task automatic test_misalign();
        logic [XLEN-1:0] addr [2];
        logic [7:0]      mask [2];
        addr[0] = 64'h4006; mask[0] = 8'h3C;
        addr[1] = 64'h4000; mask[1] = 8'h05;
        for (int k = 0; k < 2; k++) begin
            drive_load(5'd7, addr[k], mask[k], 1'b1);
            tick();
            drive_nop();
            $display("misalign addr=%h mask=%h err=%b", addr[k], mask[k], o_err);
            n_cmp++;
            if (o_err !== 1'b1 || o_ram_req !== 1'b0 || o_stall !== 1'b0 || o_wb_rd_en !== 1'b0) begin
                n_bad++;
                $display("FAIL misalign[%0d]: err=%b req=%b stall=%b wb_en=%b required 1/0/0/0", k,
                         o_err, o_ram_req, o_stall, o_wb_rd_en);
            end
            tick();
            n_cmp++;
            if (o_err !== 1'b0 || o_ram_req !== 1'b0) begin
                n_bad++;
                $display("FAIL misalign_pulse[%0d]: err=%b req=%b required 0/0", k, o_err, o_ram_req);
            end
        end
    endtask

    task automatic test_illegal();
        drive_load(5'd9, 64'h6008, 8'hFF, 1'b0);
        i_exec_ram_wr_en = 1'b1;
        i_exec_ram_data  = 64'h5A5A_0000_1111_2222;
        tick();
        drive_nop();
        $display("illegal rd+wr addr=6008 err=%b we=%b", o_err, o_ram_we);
        n_cmp++;
        if (o_ram_req !== 1'b1 || o_ram_we !== 1'b1 || o_err !== 1'b1 || o_ram_addr !== 64'h6008) begin
            n_bad++;
            $display("FAIL illegal_req: req=%b we=%b err=%b addr=%h required 1/1/1/6008",
                     o_ram_req, o_ram_we, o_err, o_ram_addr);
        end
        i_ram_ack   = 1'b1;
        i_ram_rdata = 64'h7777_7777_7777_7777;
        tick();
        i_ram_ack   = 1'b0;
        i_ram_rdata = '0;
        n_cmp++;
        if (o_err !== 1'b0 || o_wb_rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_resp: err=%b wb_en=%b required 0/0", o_err, o_wb_rd_en);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        wb_t e;
        drive_nop();
        i_exec_rd_en = 1'b1; i_exec_rd = 5'd1; i_exec_rd_reg = 64'hAAAA_0001;
        exp_q.push_back('{rd: 5'd1, data: 64'hAAAA_0001});
        tick();
        n_cmp++;
        e = exp_q.pop_front();
        if (o_wb_rd_en !== 1'b1 || {o_wb_rd, o_wb_rd_reg} !== e) begin
            n_bad++;
            $display("FAIL b2b_alu1: en=%b rd=%0d data=%h required rd=%0d data=%h",
                     o_wb_rd_en, o_wb_rd, o_wb_rd_reg, e.rd, e.data);
        end
        drive_load(5'd2, 64'h1000, 8'hFF, 1'b0);
        exp_q.push_back('{rd: 5'd2, data: 64'h0F0F_0F0F_F0F0_F0F0});
        tick();
        // The following ALU op is held by upstream for the whole stall.
        drive_nop();
        i_exec_rd_en = 1'b1; i_exec_rd = 5'd3; i_exec_rd_reg = 64'hCCCC_0003;
        i_ram_ack   = 1'b1;
        i_ram_rdata = 64'h0F0F_0F0F_F0F0_F0F0;
        tick();
        i_ram_ack   = 1'b0;
        i_ram_rdata = '0;
        n_cmp++;
        e = exp_q.pop_front();
        if (o_wb_rd_en !== 1'b1 || {o_wb_rd, o_wb_rd_reg} !== e) begin
            n_bad++;
            $display("FAIL b2b_load: en=%b rd=%0d data=%h required rd=%0d data=%h",
                     o_wb_rd_en, o_wb_rd, o_wb_rd_reg, e.rd, e.data);
        end
        exp_q.push_back('{rd: 5'd3, data: 64'hCCCC_0003});
        tick();
        n_cmp++;
        if (o_wb_rd_en !== 1'b0 || o_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_gap: wb_en=%b stall=%b required 0/0", o_wb_rd_en, o_stall);
        end
        tick();
        drive_nop();
        n_cmp++;
        e = exp_q.pop_front();
        if (o_wb_rd_en !== 1'b1 || {o_wb_rd, o_wb_rd_reg} !== e) begin
            n_bad++;
            $display("FAIL b2b_alu2: en=%b rd=%0d data=%h required rd=%0d data=%h",
                     o_wb_rd_en, o_wb_rd, o_wb_rd_reg, e.rd, e.data);
        end
        $display("b2b alu/load/alu done");
        tick();
    endtask

    task automatic test_timeout();
        int   n = 0;
        logic early_err = 1'b0;
        drive_load(5'd9, 64'h5000, 8'hFF, 1'b0);
        tick();
        drive_nop();
        while (o_ram_req === 1'b1 && n < 1000) begin
            n++;
            if (o_err === 1'b1) early_err = 1'b1;
            tick();
        end
        $display("timeout after %0d req cycles err=%b", n, o_err);
        n_cmp++;
        if (n != TIMEOUT || early_err) begin
            n_bad++;
            $display("FAIL timeout_len: got %0d cycles early_err=%b required %0d/0", n, early_err, TIMEOUT);
        end
        n_cmp++;
        if (o_err !== 1'b1 || o_stall !== 1'b0 || o_wb_rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_err: err=%b stall=%b wb_en=%b required 1/0/0", o_err, o_stall, o_wb_rd_en);
        end
        tick();
        n_cmp++;
        if (o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_pulse: err=%b required 0", o_err);
        end
    endtask

    task automatic test_reset_mid();
        drive_load(5'd10, 64'h7000, 8'hFF, 1'b0);
        tick();
        drive_nop();
        tick();
        n_cmp++;
        if (o_ram_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_pre: req=%b required 1", o_ram_req);
        end
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        $display("reset mid-access outputs=%h", all_out);
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got %h required 0", all_out);
        end
        i_rst = 1'b0;
        i_ram_ack   = 1'b1;
        i_ram_rdata = 64'h1;
        tick();
        i_ram_ack   = 1'b0;
        i_ram_rdata = '0;
        n_cmp++;
        if (o_stall !== 1'b0 || o_wb_rd_en !== 1'b0 || o_ram_req !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_idle: stall=%b wb_en=%b req=%b required 0/0/0", o_stall, o_wb_rd_en, o_ram_req);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_stores();
        test_misalign();
        test_illegal();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
